// File: rtl/uart_tx_if.sv
// Producer-side handshake and line outputs of the UART transmitter.
// The producer drives data_in/valid; the transmitter answers with ready and the line status.
interface uart_tx_if;
  logic [7:0] data_in;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output data_in,
    output valid,
    input  ready,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  valid,
    output ready,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with a one-entry holding register, so frames run back-to-back.
// Every output is a flop; next-state logic computes the following cycle's line level directly.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 2
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state,     state_n;
  logic [BAUD_W-1:0] baud_cnt,  baud_n;
  logic [2:0]        bit_cnt,   bit_n;
  logic              stop_cnt,  stop_n;
  logic [7:0]        shift_reg, shift_n;
  logic [7:0]        hold_data, hold_data_n;
  logic              hold_full, hold_full_n;
  logic              tx_q,      tx_n;
  logic              ready_q,   ready_n;
  logic              busy_q,    busy_n;
  logic              done_q,    done_n;
  logic              accept;
  logic              load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shift_reg <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      stop_cnt  <= stop_n;
      shift_reg <= shift_n;
      hold_data <= hold_data_n;
      hold_full <= hold_full_n;
      tx_q      <= tx_n;
      ready_q   <= ready_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
    end
  end

  // tx_n is the line level for the cycle after this edge, so tx comes straight off a flop.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    stop_n  = stop_cnt;
    shift_n = shift_reg;
    tx_n    = 1'b1;
    load    = 1'b0;
    accept  = bus.valid && ready_q;

    case (state)
      IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          shift_n = hold_data;
          state_n = START;
          baud_n  = '0;
          tx_n    = 1'b0;
        end
      end

      START: begin
        if (baud_cnt == BAUD_LAST) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = 3'd0;
          tx_n    = shift_reg[0];
        end else begin
          baud_n  = baud_cnt + 1'b1;
          tx_n    = 1'b0;
        end
      end

      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n  = '0;
          shift_n = {1'b0, shift_reg[7:1]};
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            stop_n  = 1'b0;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_cnt + 3'd1;
            tx_n    = shift_reg[1];
          end
        end else begin
          baud_n  = baud_cnt + 1'b1;
          tx_n    = shift_reg[0];
        end
      end

      STOP: begin
        tx_n = 1'b1;
        if (baud_cnt == BAUD_LAST) begin
          baud_n = '0;
          if (stop_cnt == STOP_LAST) begin
            stop_n = 1'b0;
            if (hold_full) begin
              load    = 1'b1;
              shift_n = hold_data;
              state_n = START;
              tx_n    = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            stop_n = stop_cnt + 1'b1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        baud_n  = '0;
        bit_n   = 3'd0;
        stop_n  = 1'b0;
      end
    endcase

    // accept and load are mutually exclusive: accept needs ready, load needs hold_full.
    hold_data_n = accept ? bus.data_in : hold_data;
    if (accept) begin
      hold_full_n = 1'b1;
    end else if (load) begin
      hold_full_n = 1'b0;
    end else begin
      hold_full_n = hold_full;
    end

    ready_n = !hold_full_n;
    busy_n  = (state_n != IDLE);
    done_n  = (state_n == STOP) && (baud_n == BAUD_LAST) && (stop_n == STOP_LAST);
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
